// File: rtl/data_cache_wb.sv
// Set-associative write-back, write-allocate data cache with a stalling CPU port
// and a burst writeback/refill port toward main memory.
module data_cache_wb #(
  parameter int XLEN       = 32,
  parameter int SETS       = 128,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_ctrl,
  output logic [XLEN-1:0] rdata,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;
  localparam int IW  = $clog2(SETS);
  localparam int TW  = XLEN - IW - OFF;
  localparam int PW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NB  = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state_reg;

  logic            valid_reg [WAYS][SETS];
  logic            dirty_reg [WAYS][SETS];
  logic [TW-1:0]   tag_reg   [WAYS][SETS];
  logic [XLEN-1:0] data_reg  [WAYS][SETS][LINE_WORDS];
  logic [PW-1:0]   ptr_reg   [SETS];

  logic [PW-1:0] victim_reg;
  logic [IW-1:0] miss_index_reg;
  logic [TW-1:0] miss_tag_reg;
  logic [BW-1:0] beat_reg;
  logic [BW-1:0] beat_next;
  logic          last_beat;

  logic [BW-1:0] word_sel;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;

  assign word_sel  = req_addr[OFF-1:2];
  assign index     = req_addr[OFF+IW-1:OFF];
  assign tag       = req_addr[XLEN-1:OFF+IW];
  assign beat_next = beat_reg + 1'b1;
  assign last_beat = (beat_reg == BW'(LINE_WORDS - 1));

  logic [WAYS-1:0] way_hit;
  logic            hit;
  logic            lookup;
  logic [PW-1:0]   hit_way;
  logic [PW-1:0]   victim_way;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_hit[gi] = valid_reg[gi][index] && (tag_reg[gi][index] == tag);
    end
  endgenerate

  // Downward scan leaves the lowest-index match / invalid way as the winner.
  always_comb begin
    hit_way    = '0;
    victim_way = (WAYS > 1) ? ptr_reg[index] : '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) hit_way = PW'(w);
      if (!valid_reg[w][index]) victim_way = PW'(w);
    end
  end

  assign hit    = |way_hit;
  assign lookup = (state_reg == IDLE) && req_valid;
  assign stall  = (state_reg != IDLE) || (req_valid && !hit);

  logic [XLEN-1:0] hit_word;
  logic [XLEN-1:0] load_val;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;

  always_comb begin
    hit_word  = data_reg[hit_way][index][word_sel];
    lane_byte = 8'(hit_word >> {req_addr[1:0], 3'b000});
    lane_half = req_addr[1] ? hit_word[31:16] : hit_word[15:0];
    case (req_ctrl)
      3'b000:  load_val = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{(XLEN-16){lane_half[15]}}, lane_half};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, lane_byte};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, lane_half};
      default: load_val = hit_word;
    endcase
  end

  assign rdata = (lookup && hit && !req_we) ? load_val : '0;

  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] merged;

  always_comb begin
    case (req_ctrl)
      3'b000: begin
        byte_en    = NB'(1) << req_addr[1:0];
        store_data = {NB{req_wdata[7:0]}};
      end
      3'b001: begin
        byte_en    = req_addr[1] ? NB'(4'b1100) : NB'(4'b0011);
        store_data = {(NB/2){req_wdata[15:0]}};
      end
      default: begin
        byte_en    = '1;
        store_data = req_wdata;
      end
    endcase
  end

  generate
    for (gi = 0; gi < NB; gi++) begin : g_merge
      assign merged[8*gi +: 8] = byte_en[gi] ? store_data[8*gi +: 8] : hit_word[8*gi +: 8];
    end
  endgenerate

  // Line data carries no reset; only the valid bits decide what is usable.
  always_ff @(posedge clk) begin
    if (!rst && lookup && hit && req_we)
      data_reg[hit_way][index][word_sel] <= merged;
    else if (!rst && state_reg == REFILL && mem_ready)
      data_reg[victim_reg][miss_index_reg][beat_reg] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      victim_reg     <= '0;
      miss_index_reg <= '0;
      miss_tag_reg   <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[w][s] <= 1'b0;
          dirty_reg[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && !hit) begin
            victim_reg     <= victim_way;
            miss_index_reg <= index;
            miss_tag_reg   <= tag;
            beat_reg       <= '0;
            mem_req        <= 1'b1;
            // Victim is invalidated up front so an aborted burst never leaves a mixed line usable.
            valid_reg[victim_way][index] <= 1'b0;
            dirty_reg[victim_way][index] <= 1'b0;
            if (valid_reg[victim_way][index] && dirty_reg[victim_way][index]) begin
              state_reg <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_reg[victim_way][index], index, {BW{1'b0}}, 2'b00};
              mem_wdata <= data_reg[victim_way][index][0];
            end else begin
              state_reg <= REFILL;
              mem_we    <= 1'b0;
              mem_addr  <= {tag, index, {BW{1'b0}}, 2'b00};
              mem_wdata <= '0;
            end
          end else if (req_valid && req_we) begin
            dirty_reg[hit_way][index] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              state_reg <= REFILL;
              beat_reg  <= '0;
              mem_we    <= 1'b0;
              mem_addr  <= {miss_tag_reg, miss_index_reg, {BW{1'b0}}, 2'b00};
              mem_wdata <= '0;
            end else begin
              beat_reg  <= beat_next;
              mem_addr  <= {tag_reg[victim_reg][miss_index_reg], miss_index_reg, beat_next, 2'b00};
              mem_wdata <= data_reg[victim_reg][miss_index_reg][beat_next];
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (last_beat) begin
              valid_reg[victim_reg][miss_index_reg] <= 1'b1;
              dirty_reg[victim_reg][miss_index_reg] <= 1'b0;
              tag_reg[victim_reg][miss_index_reg]   <= miss_tag_reg;
              ptr_reg[miss_index_reg] <= (WAYS > 1) ? ptr_reg[miss_index_reg] + 1'b1 : '0;
              state_reg <= IDLE;
              beat_reg  <= '0;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
            end else begin
              beat_reg <= beat_next;
              mem_addr <= {miss_tag_reg, miss_index_reg, beat_next, 2'b00};
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_wb.sv
// Directed bench for data_cache_wb: a word-addressed memory model answers bursts,
// and each scenario task checks stall counts, beat traces and load results.
module tb_data_cache_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int hold_err = 0;

  logic [31:0] mem [0:4095];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t beat_q[$];

  data_cache_wb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ctrl  (req_ctrl),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 32'h1000 + i;
  end

  always @(posedge clk) begin
    if (!rst && mem_req === 1'b1 && mem_ready === 1'b1) begin
      beat_q.push_back({mem_we, mem_addr, mem_wdata});
      if (mem_we) mem[mem_addr[13:2]] <= mem_wdata;
    end
  end

  // pat 0: mem_ready always high; pat 1: ready on every third burst cycle (1,0,0,1,...)
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] ctrl, input int pat,
                        output int stalls, output logic [31:0] rd);
    int          k;
    logic        held;
    logic [31:0] held_addr;
    stalls = 0; k = 0; held = 1'b0; held_addr = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_ctrl = ctrl;
    #1;
    while (stall !== 1'b0 && stalls < 200) begin
      stalls++;
      if (mem_req === 1'b1) begin
        if (held && mem_addr !== held_addr) hold_err++;
        mem_ready = (pat == 0) || (k % 3 == 0);
        held = !mem_ready;
        held_addr = mem_addr;
        k++;
      end else begin
        mem_ready = 1'b0;
        held = 1'b0;
      end
      @(negedge clk); #1;
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL access_timeout addr=%h stall=%b required=0", addr, stall);
    end
    rd = rdata;
    $display("txn we=%0d addr=%h ctrl=%b wdata=%h stalls=%0d rdata=%h", we, addr, ctrl, wd, stalls, rd);
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_ctrl = 3'b010; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int st; logic [31:0] rd;
    beat_q.delete();
    access(1'b0, 32'h40, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 5) begin failures++; $display("FAIL cold_stalls got=%0d exp=5", st); end
    checks++; if (rd !== 32'h1010) begin failures++; $display("FAIL cold_rdata got=%h exp=00001010", rd); end
    checks++; if (beat_q.size() != 4) begin failures++; $display("FAIL cold_beats got=%0d exp=4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++;
      if (beat_q[i].we !== 1'b0 || beat_q[i].addr !== 32'h40 + 4*i) begin
        failures++;
        $display("FAIL cold_beat%0d got we=%b addr=%h exp we=0 addr=%h", i, beat_q[i].we, beat_q[i].addr, 32'h40 + 4*i);
      end
    end
    access(1'b0, 32'h44, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 0) begin failures++; $display("FAIL hit_stalls got=%0d exp=0", st); end
    checks++; if (rd !== 32'h1011) begin failures++; $display("FAIL hit_rdata got=%h exp=00001011", rd); end
  endtask

  task automatic test_byte_half();
    int st; logic [31:0] rd;
    beat_q.delete();
    access(1'b1, 32'h41, 32'hAB, 3'b000, 0, st, rd);
    checks++; if (st != 0 || rd !== 32'h0) begin failures++; $display("FAIL sb_hit got stalls=%0d rdata=%h exp 0/0", st, rd); end
    access(1'b0, 32'h41, 32'h0, 3'b100, 0, st, rd);
    checks++; if (rd !== 32'h000000AB) begin failures++; $display("FAIL lbu got=%h exp=000000ab", rd); end
    access(1'b0, 32'h41, 32'h0, 3'b000, 0, st, rd);
    checks++; if (rd !== 32'hFFFFFFAB) begin failures++; $display("FAIL lb got=%h exp=ffffffab", rd); end
    access(1'b1, 32'h42, 32'h8001, 3'b001, 0, st, rd);
    access(1'b0, 32'h42, 32'h0, 3'b001, 0, st, rd);
    checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    access(1'b0, 32'h42, 32'h0, 3'b101, 0, st, rd);
    checks++; if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", rd); end
    access(1'b0, 32'h40, 32'h0, 3'b010, 0, st, rd);
    checks++; if (rd !== 32'h8001AB10) begin failures++; $display("FAIL merged_word got=%h exp=8001ab10", rd); end
    checks++; if (beat_q.size() != 0) begin failures++; $display("FAIL byte_half_no_mem got=%0d beats exp=0", beat_q.size()); end
  endtask

  task automatic test_dirty_eviction();
    int st; logic [31:0] rd;
    logic [31:0] wb_exp [4];
    wb_exp[0] = 32'h8001AB10; wb_exp[1] = 32'h1011; wb_exp[2] = 32'h1012; wb_exp[3] = 32'h1013;
    access(1'b0, 32'h1040, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 5 || rd !== 32'h1410) begin failures++; $display("FAIL fill_way1 got stalls=%0d rdata=%h exp 5/00001410", st, rd); end
    beat_q.delete();
    access(1'b0, 32'h2040, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 9) begin failures++; $display("FAIL dirty_stalls got=%0d exp=9", st); end
    checks++; if (rd !== 32'h1810) begin failures++; $display("FAIL dirty_rdata got=%h exp=00001810", rd); end
    checks++; if (beat_q.size() != 8) begin failures++; $display("FAIL dirty_beats got=%0d exp=8", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++;
      if (beat_q[i].we !== 1'b1 || beat_q[i].addr !== 32'h40 + 4*i || beat_q[i].data !== wb_exp[i]) begin
        failures++;
        $display("FAIL wb_beat%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                 i, beat_q[i].we, beat_q[i].addr, beat_q[i].data, 32'h40 + 4*i, wb_exp[i]);
      end
    end
    for (int i = 4; i < beat_q.size() && i < 8; i++) begin
      checks++;
      if (beat_q[i].we !== 1'b0 || beat_q[i].addr !== 32'h2040 + 4*(i-4)) begin
        failures++;
        $display("FAIL rf_beat%0d got we=%b addr=%h exp we=0 addr=%h", i, beat_q[i].we, beat_q[i].addr, 32'h2040 + 4*(i-4));
      end
    end
    access(1'b0, 32'h1040, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 0 || rd !== 32'h1410) begin failures++; $display("FAIL way1_kept got stalls=%0d rdata=%h exp 0/00001410", st, rd); end
  endtask

  task automatic test_clean_eviction();
    int st; int wb; logic [31:0] rd;
    beat_q.delete();
    access(1'b0, 32'h40, 32'h0, 3'b010, 0, st, rd);
    wb = 0;
    foreach (beat_q[i]) if (beat_q[i].we) wb++;
    checks++; if (st != 5) begin failures++; $display("FAIL clean_stalls got=%0d exp=5", st); end
    checks++; if (wb != 0 || beat_q.size() != 4) begin failures++; $display("FAIL clean_beats got wb=%0d total=%0d exp 0/4", wb, beat_q.size()); end
    checks++; if (rd !== 32'h8001AB10) begin failures++; $display("FAIL clean_rdata got=%h exp=8001ab10", rd); end
  endtask

  task automatic test_refill_toggle();
    int st; logic [31:0] rd;
    beat_q.delete(); hold_err = 0;
    access(1'b0, 32'h880, 32'h0, 3'b010, 1, st, rd);
    checks++; if (st != 11) begin failures++; $display("FAIL toggle_stalls got=%0d exp=11", st); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL toggle_hold got=%0d moves exp=0", hold_err); end
    checks++; if (beat_q.size() != 4) begin failures++; $display("FAIL toggle_beats got=%0d exp=4", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 4; i++) begin
      checks++;
      if (beat_q[i].addr !== 32'h880 + 4*i) begin
        failures++;
        $display("FAIL toggle_beat%0d got addr=%h exp=%h", i, beat_q[i].addr, 32'h880 + 4*i);
      end
    end
    checks++; if (rd !== 32'h1220) begin failures++; $display("FAIL toggle_rdata got=%h exp=00001220", rd); end
    access(1'b0, 32'h88C, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 0 || rd !== 32'h1223) begin failures++; $display("FAIL toggle_last got stalls=%0d rdata=%h exp 0/00001223", st, rd); end
  endtask

  task automatic test_store_miss();
    int st; logic [31:0] rd;
    access(1'b1, 32'hC84, 32'hDEADBEEF, 3'b010, 0, st, rd);
    checks++; if (st != 5) begin failures++; $display("FAIL sw_miss_stalls got=%0d exp=5", st); end
    access(1'b0, 32'hC84, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_miss_data got stalls=%0d rdata=%h exp 0/deadbeef", st, rd); end
    access(1'b0, 32'hC80, 32'h0, 3'b010, 0, st, rd);
    checks++; if (rd !== 32'h1320) begin failures++; $display("FAIL sw_miss_neighbour got=%h exp=00001320", rd); end
  endtask

  task automatic test_reset_mid_burst();
    int st; int cyc; logic [31:0] rd;
    beat_q.delete(); cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3080; req_ctrl = 3'b010;
    #1;
    while (beat_q.size() < 2 && cyc < 50) begin
      mem_ready = mem_req;
      @(negedge clk); #1;
      cyc++;
    end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3088) begin failures++; $display("FAIL rst_beat2 got req=%b addr=%h exp 1/00003088", mem_req, mem_addr); end
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_abort_req got=%b exp=0", mem_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_abort_stall got=%b exp=0", stall); end
    rst = 1'b0;
    $display("txn reset during refill of 3080");
    beat_q.delete();
    access(1'b0, 32'h3080, 32'h0, 3'b010, 0, st, rd);
    checks++; if (st != 5 || beat_q.size() != 4) begin failures++; $display("FAIL rst_reissue got stalls=%0d beats=%0d exp 5/4", st, beat_q.size()); end
    checks++; if (rd !== 32'h1C20) begin failures++; $display("FAIL rst_reissue_rdata got=%h exp=00001c20", rd); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_byte_half();
    test_dirty_eviction();
    test_clean_eviction();
    test_refill_toggle();
    test_store_miss();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
